// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall sequencer for the 5-stage core.
// It covers the hazards that forwarding cannot resolve: load-use stalls,
// taken-branch flushes, instruction-memory bubbles and data-memory freezes.
// It drives the PC and pipeline-register enables/flushes, watches for a
// stuck data memory and keeps saturating performance counters.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_RUN   | normal issue; load-use / icache bubbles handled in place
//   S_DWAIT | data memory busy, whole pipe frozen; flush_cnt kept so an
//           | interrupted branch flush resumes after release
//   S_FLUSH | extra wrong-path flush cycles after a taken branch
//
// Control outputs are combinational from state and current inputs so the
// pipeline registers see them in the same cycle the hazard is visible.
module hazard_ctrl #(
    parameter int FLUSH_EXTRA = 0,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFID_RS1,
    input  logic [4:0]       IFID_RS2,
    input  logic             IFID_USE_RS2,
    input  logic [4:0]       IDEX_RD,
    input  logic             IDEX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             ICACHE_STALL,
    input  logic             DCACHE_STALL,
    output logic             PC_WRITE,
    output logic             PC_SRC,
    output logic             IFID_WRITE,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             EXMEM_WRITE,
    output logic             MEMWB_WRITE,
    output logic             STALL_TIMEOUT,
    output logic [CNT_W-1:0] LU_STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT,
    output logic [CNT_W-1:0] DSTALL_CNT
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_EXTRA);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [16:0]      TO_LIMIT   = 17'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  flush_cnt;
    logic [1:0]  flush_cnt_nxt;
    logic [15:0] to_cnt;
    logic [16:0] to_inc;

    logic        flush_active;
    logic        lu_hazard;
    logic        br_take;
    logic        flush_cyc;
    logic        lu_stall;

    // Hazard qualification. A freeze taken during FLUSH leaves flush_cnt
    // non-zero, which is how DWAIT knows to return to FLUSH.
    always_comb begin
        flush_active = (state == S_FLUSH) || ((state == S_DWAIT) && (flush_cnt != 2'd0));
        lu_hazard    = IDEX_MemRead && (IDEX_RD != 5'd0) &&
                       ((IDEX_RD == IFID_RS1) || (IFID_USE_RS2 && (IDEX_RD == IFID_RS2)));
        br_take      = !DCACHE_STALL && EX_BranchTaken && !flush_active;
        flush_cyc    = !DCACHE_STALL && flush_active;
        lu_stall     = !DCACHE_STALL && !flush_active && !EX_BranchTaken && lu_hazard;
        to_inc       = {1'b0, to_cnt} + 17'd1;
    end

    // Pipeline control outputs, highest-priority hazard first; reset holds
    // every register closed and NOPs in IF/ID and ID/EX.
    always_comb begin
        PC_WRITE    = 1'b1;
        PC_SRC      = 1'b0;
        IFID_WRITE  = 1'b1;
        IFID_FLUSH  = 1'b0;
        IDEX_FLUSH  = 1'b0;
        EXMEM_WRITE = 1'b1;
        MEMWB_WRITE = 1'b1;
        if (!rst_n) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            EXMEM_WRITE = 1'b0;
            MEMWB_WRITE = 1'b0;
        end else if (DCACHE_STALL) begin
            // EX is frozen too, so a taken branch is simply re-seen on release
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            EXMEM_WRITE = 1'b0;
            MEMWB_WRITE = 1'b0;
        end else if (br_take) begin
            // redirect wins over an icache miss: the fetched word is discarded anyway
            PC_SRC      = 1'b1;
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
        end else if (flush_cyc) begin
            PC_WRITE    = !ICACHE_STALL;
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
        end else if (lu_hazard) begin
            // hold IF/ID (not flush) so the dependent instruction is retried
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_FLUSH  = 1'b1;
        end else if (ICACHE_STALL) begin
            PC_WRITE    = 1'b0;
            IFID_FLUSH  = 1'b1;
        end
    end

    // Next-state and flush-count selection.
    always_comb begin
        state_nxt     = S_RUN;
        flush_cnt_nxt = flush_cnt;
        if (DCACHE_STALL) begin
            state_nxt     = S_DWAIT;
        end else if (br_take) begin
            if (FLUSH_INIT != 2'd0) begin
                state_nxt     = S_FLUSH;
                flush_cnt_nxt = FLUSH_INIT;
            end else begin
                state_nxt     = S_RUN;
                flush_cnt_nxt = 2'd0;
            end
        end else if (flush_cyc) begin
            if (flush_cnt <= 2'd1) begin
                state_nxt     = S_RUN;
                flush_cnt_nxt = 2'd0;
            end else begin
                state_nxt     = S_FLUSH;
                flush_cnt_nxt = flush_cnt - 2'd1;
            end
        end
    end

    // State and remaining-flush register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Data-memory watchdog: counts consecutive freeze cycles, sticky flag
    // once the limit is reached; the count parks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt        <= 16'd0;
            STALL_TIMEOUT <= 1'b0;
        end else if (DCACHE_STALL) begin
            if (to_cnt != 16'hFFFF) begin
                to_cnt <= to_inc[15:0];
            end
            if (to_inc >= TO_LIMIT) begin
                STALL_TIMEOUT <= 1'b1;
            end
        end else begin
            to_cnt <= 16'd0;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LU_STALL_CNT <= '0;
            FLUSH_CNT    <= '0;
            DSTALL_CNT   <= '0;
        end else begin
            if (lu_stall && (LU_STALL_CNT != CNT_MAX)) begin
                LU_STALL_CNT <= LU_STALL_CNT + CNT_ONE;
            end
            if (br_take && (FLUSH_CNT != CNT_MAX)) begin
                FLUSH_CNT <= FLUSH_CNT + CNT_ONE;
            end
            if (DCACHE_STALL && (DSTALL_CNT != CNT_MAX)) begin
                DSTALL_CNT <= DSTALL_CNT + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (FLUSH_EXTRA=2, TIMEOUT=3, CNT_W=4 so counter
// saturation is reachable). Each vector pushes its expected controls,
// counters and flag to a queue; they are popped and compared at the
// following negedge.
module tb_hazard_ctrl;

    localparam logic [6:0] O_RUN  = 7'b1010011;
    localparam logic [6:0] O_BR   = 7'b1111111;
    localparam logic [6:0] O_DC   = 7'b0000000;
    localparam logic [6:0] O_FL   = 7'b1011111;
    localparam logic [6:0] O_FLIC = 7'b0011111;
    localparam logic [6:0] O_LU   = 7'b0000111;
    localparam logic [6:0] O_IC   = 7'b0011011;
    localparam logic [6:0] O_RST  = 7'b0001100;

    typedef struct packed {
        logic [6:0] ctl;
        logic [3:0] lu;
        logic [3:0] fl;
        logic [3:0] ds;
        logic       to;
    } exp_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       ic;
        logic       dc;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] IFID_RS1 = '0, IFID_RS2 = '0, IDEX_RD = '0;
    logic       IFID_USE_RS2 = 1'b0, IDEX_MemRead = 1'b0, EX_BranchTaken = 1'b0;
    logic       ICACHE_STALL = 1'b0, DCACHE_STALL = 1'b0;
    logic       PC_WRITE, PC_SRC, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH;
    logic       EXMEM_WRITE, MEMWB_WRITE, STALL_TIMEOUT;
    logic [3:0] LU_STALL_CNT, FLUSH_CNT, DSTALL_CNT;

    exp_t obs;
    exp_t exp_q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_EXTRA(2), .TIMEOUT(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_RS1(IFID_RS1), .IFID_RS2(IFID_RS2), .IFID_USE_RS2(IFID_USE_RS2),
        .IDEX_RD(IDEX_RD), .IDEX_MemRead(IDEX_MemRead),
        .EX_BranchTaken(EX_BranchTaken), .ICACHE_STALL(ICACHE_STALL),
        .DCACHE_STALL(DCACHE_STALL),
        .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC), .IFID_WRITE(IFID_WRITE),
        .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH),
        .EXMEM_WRITE(EXMEM_WRITE), .MEMWB_WRITE(MEMWB_WRITE),
        .STALL_TIMEOUT(STALL_TIMEOUT), .LU_STALL_CNT(LU_STALL_CNT),
        .FLUSH_CNT(FLUSH_CNT), .DSTALL_CNT(DSTALL_CNT)
    );

    assign obs = {PC_WRITE, PC_SRC, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH, EXMEM_WRITE,
                  MEMWB_WRITE, LU_STALL_CNT, FLUSH_CNT, DSTALL_CNT, STALL_TIMEOUT};

    function automatic vec_t mkv(int rs1, int rs2, int use2, int rd, int mr, int br,
                                 int ic, int dc, logic [6:0] ctl, int lu, int fl,
                                 int ds, int to);
        vec_t v;
        v.rs1 = 5'(rs1);  v.rs2 = 5'(rs2);  v.use2 = 1'(use2);  v.rd = 5'(rd);
        v.mr = 1'(mr);    v.br = 1'(br);    v.ic = 1'(ic);      v.dc = 1'(dc);
        v.e.ctl = ctl;    v.e.lu = 4'(lu);  v.e.fl = 4'(fl);    v.e.ds = 4'(ds);
        v.e.to = 1'(to);
        return v;
    endfunction

    task automatic set_inputs(input vec_t v);
        IFID_RS1 = v.rs1; IFID_RS2 = v.rs2; IFID_USE_RS2 = v.use2; IDEX_RD = v.rd;
        IDEX_MemRead = v.mr; EX_BranchTaken = v.br; ICACHE_STALL = v.ic; DCACHE_STALL = v.dc;
    endtask

    // drive one vector just after the clock edge and queue its expectation
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        set_inputs(v);
        exp_q.push_back(v.e);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        set_inputs(mkv(0,0,0,0,0,0,0,0, O_RUN,0,0,0,0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        vec_t v[2];
        v[0] = mkv(0,0,0,0,0,0,0,0, O_RUN,0,0,0,0);
        v[1] = mkv(0,0,0,0,0,0,0,0, O_RUN,0,0,0,0);
        #1;
        exp_q.push_back(mkv(0,0,0,0,0,0,0,0, O_RST,0,0,0,0).e);
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset: got %b required %b", obs, e);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset_run[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_no_stall;
        vec_t v[4];
        v[0] = mkv(0,0,0,0,1,0,0,0, O_RUN,0,0,0,0);   // load to x0, reads x0
        v[1] = mkv(3,7,0,7,1,0,0,0, O_RUN,0,0,0,0);   // rs2 match but unused
        v[2] = mkv(3,7,1,8,1,0,0,0, O_RUN,0,0,0,0);   // no register match
        v[3] = mkv(5,0,0,5,0,0,0,0, O_RUN,0,0,0,0);   // match, not a load
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL no_stall[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_load_use;
        vec_t v[4];
        v[0] = mkv(5,0,0,5,1,0,0,0, O_LU, 0,0,0,0);
        v[1] = mkv(6,0,0,0,0,0,0,0, O_RUN,1,0,0,0);
        v[2] = mkv(1,9,1,9,1,0,0,0, O_LU, 1,0,0,0);
        v[3] = mkv(1,9,1,0,0,0,0,0, O_RUN,2,0,0,0);
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL load_use[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_icache;
        vec_t v[3];
        v[0] = mkv(0,0,0,0,0,0,1,0, O_IC, 2,0,0,0);
        v[1] = mkv(4,0,0,4,1,0,1,0, O_LU, 2,0,0,0);   // load-use beats bubble
        v[2] = mkv(0,0,0,0,0,0,0,0, O_RUN,3,0,0,0);
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL icache[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_branch;
        vec_t v[8];
        v[0] = mkv(0,0,0,0,0,1,0,0, O_BR,  0,0,0,0);
        v[1] = mkv(0,0,0,0,0,0,0,0, O_FL,  0,1,0,0);
        v[2] = mkv(0,0,0,0,0,0,0,0, O_FL,  0,1,0,0);
        v[3] = mkv(0,0,0,0,0,0,0,0, O_RUN, 0,1,0,0);
        v[4] = mkv(5,0,0,5,1,1,1,0, O_BR,  0,1,0,0);  // branch beats icache and load-use
        v[5] = mkv(5,0,0,5,1,1,1,0, O_FLIC,0,2,0,0);  // wrong-path branch ignored
        v[6] = mkv(0,0,0,0,0,0,0,0, O_FL,  0,2,0,0);
        v[7] = mkv(0,0,0,0,0,0,0,0, O_RUN, 0,2,0,0);
        do_reset();
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL branch[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_dstall_branch;
        vec_t v[8];
        v[0] = mkv(0,0,0,0,0,1,0,1, O_DC, 0,0,0,0);
        v[1] = mkv(0,0,0,0,0,1,0,1, O_DC, 0,0,1,0);
        v[2] = mkv(0,0,0,0,0,1,0,1, O_DC, 0,0,2,0);
        v[3] = mkv(0,0,0,0,0,1,0,1, O_DC, 0,0,3,1);
        v[4] = mkv(0,0,0,0,0,1,0,0, O_BR, 0,0,4,1);
        v[5] = mkv(0,0,0,0,0,0,0,0, O_FL, 0,1,4,1);
        v[6] = mkv(0,0,0,0,0,0,0,0, O_FL, 0,1,4,1);
        v[7] = mkv(0,0,0,0,0,0,0,0, O_RUN,0,1,4,1);
        do_reset();
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL dstall_branch[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_timeout;
        vec_t v[7];
        v[0] = mkv(0,0,0,0,0,0,0,1, O_DC, 0,0,0,0);
        v[1] = mkv(0,0,0,0,0,0,0,1, O_DC, 0,0,1,0);
        v[2] = mkv(0,0,0,0,0,0,0,1, O_DC, 0,0,2,0);
        v[3] = mkv(0,0,0,0,0,0,0,1, O_DC, 0,0,3,1);
        v[4] = mkv(0,0,0,0,0,0,0,1, O_DC, 0,0,4,1);
        v[5] = mkv(0,0,0,0,0,0,0,0, O_RUN,0,0,5,1);
        v[6] = mkv(0,0,0,0,0,0,0,0, O_RUN,0,0,5,1);
        do_reset();
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL timeout[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_flush_resume;
        vec_t v[6];
        v[0] = mkv(0,0,0,0,0,1,0,0, O_BR, 0,0,0,0);
        v[1] = mkv(0,0,0,0,0,0,0,1, O_DC, 0,1,0,0);
        v[2] = mkv(0,0,0,0,0,0,0,1, O_DC, 0,1,1,0);
        v[3] = mkv(0,0,0,0,0,1,0,0, O_FL, 0,1,2,0);   // resumes flush, branch ignored
        v[4] = mkv(0,0,0,0,0,0,0,0, O_FL, 0,1,2,0);
        v[5] = mkv(0,0,0,0,0,0,0,0, O_RUN,0,1,2,0);
        do_reset();
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL flush_resume[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_saturation;
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            if (k < 20)
                apply(mkv(0,0,0,0,0,0,0,1, O_DC, 0,0,(k > 15) ? 15 : k,(k >= 3) ? 1 : 0));
            else
                apply(mkv(0,0,0,0,0,0,0,0, O_RUN,0,0,15,1));
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL saturation[%0d]: got %b required %b", k, obs, e);
            end
        end
    endtask

    task automatic test_async_reset;
        vec_t v[3];
        v[0] = mkv(0,0,0,0,0,1,0,0, O_BR, 0,0,0,0);
        v[1] = mkv(0,0,0,0,0,0,0,0, O_RUN,0,0,0,0);
        v[2] = mkv(0,0,0,0,0,0,0,0, O_RUN,0,0,0,0);
        do_reset();
        apply(v[0]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL async_reset_br: got %b required %b", obs, e);
        end
        apply(mkv(0,0,0,0,0,1,0,0, O_FL, 0,1,0,0));
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL async_reset_flush: got %b required %b", obs, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mkv(0,0,0,0,0,0,0,0, O_RST,0,0,0,0).e);
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL async_reset_hold: got %b required %b", obs, e);
        end
        set_inputs(v[1]);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 1; i < 3; i++) begin
            apply(v[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL async_reset_after[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_no_stall();
        test_load_use();
        test_icache();
        test_branch();
        test_dstall_branch();
        test_timeout();
        test_flush_resume();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage RISC-V core. It sits beside the forwarding unit and covers the hazards that forwarding cannot resolve:
- load-use stalls,
- taken-branch flushes,
- instruction-memory bubbles,
- data-memory freezes.
It drives the PC and pipeline-register write/flush controls, tracks a data-memory timeout and keeps saturating performance counters.

Parameters:
FLUSH_EXTRA, 0, additional flush cycles after a taken branch (0..3)
TIMEOUT, 255, consecutive DCACHE_STALL cycles before STALL_TIMEOUT is set (1..65535)
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
IFID_RS1  input  5  rs1 of instruction in ID
IFID_RS2  input  5  rs2 of instruction in ID
IFID_USE_RS2  input  1  ID instruction reads rs2
IDEX_RD  input  5  rd of instruction in EX
IDEX_MemRead  input  1  EX instruction is a load
EX_BranchTaken  input  1  branch/jump in EX resolved taken
ICACHE_STALL  input  1  instruction memory cannot deliver this cycle
DCACHE_STALL  input  1  data memory access in MEM not complete
PC_WRITE  output  1  PC register enable
PC_SRC  output  1  1 = load branch target into PC
IFID_WRITE  output  1  IF/ID register enable
IFID_FLUSH  output  1  load NOP into IF/ID
IDEX_FLUSH  output  1  load NOP (control bits zero) into ID/EX
EXMEM_WRITE  output  1  EX/MEM enable
MEMWB_WRITE  output  1  MEM/WB enable
STALL_TIMEOUT  output  1  sticky: data memory exceeded TIMEOUT
LU_STALL_CNT  output  CNT_W  load-use stall cycles
FLUSH_CNT  output  CNT_W  taken-branch events
DSTALL_CNT  output  CNT_W  DCACHE_STALL cycles

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n=0:
  - state=RUN, flush counter=0, STALL_TIMEOUT=0, all counters=0.
  - PC_WRITE, PC_SRC, IFID_WRITE, EXMEM_WRITE, MEMWB_WRITE = 0.
  - IFID_FLUSH, IDEX_FLUSH = 1.
- Outputs are combinational from state and current inputs. State, counters and the flag are registered.
- States:
  - RUN: normal operation.
  - DWAIT: data memory freeze.
  - FLUSH: extra branch flush cycles.
- Default in RUN with no hazard: all *_WRITE=1, flushes=0, PC_SRC=0.
- Priority each cycle, highest first:
  1. DCACHE_STALL=1, any state:
     - All *_WRITE=0, PC_SRC=0, flushes=0.
     - Next state is DWAIT. A FLUSH in progress resumes with its remaining count after release.
     - EX_BranchTaken is ignored. EX is frozen and re-evaluates the branch on release.
  2. EX_BranchTaken=1, state RUN or DWAIT:
     - PC_WRITE=1, PC_SRC=1, IFID_FLUSH=1, IDEX_FLUSH=1, EX/MEM and MEM/WB enables=1.
     - This applies regardless of ICACHE_STALL.
     - FLUSH_CNT+1.
     - If FLUSH_EXTRA>0: next state is FLUSH with counter=FLUSH_EXTRA. Otherwise next state is RUN.
  3. State FLUSH:
     - PC_WRITE=!ICACHE_STALL, PC_SRC=0, IFID_FLUSH=1, IDEX_FLUSH=1.
     - Counter decrements. Exit to RUN after the cycle in which the counter reaches 1.
     - EX_BranchTaken here is a wrong-path artefact and is ignored.
  4. Load-use hazard: IDEX_MemRead && IDEX_RD!=0 && (IDEX_RD==IFID_RS1 || (IFID_USE_RS2 && IDEX_RD==IFID_RS2)).
     - PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1, IFID_FLUSH=0.
     - LU_STALL_CNT+1.
     - Lasts exactly one cycle, because the load advances to MEM.
  5. ICACHE_STALL=1:
     - PC_WRITE=0, IFID_WRITE=1, IFID_FLUSH=1 (bubble enters ID). Rest of pipeline proceeds.
     - If load-use also holds, rule 4 wins and IF/ID holds rather than being flushed.
- DWAIT leaves on the first cycle with DCACHE_STALL=0. The return state is RUN or FLUSH. Priorities 2-5 apply in that same cycle.
- Timeout counter (16 bits, internal):
  - Increments every DCACHE_STALL cycle and clears on any DCACHE_STALL=0 cycle.
  - Reaching TIMEOUT sets STALL_TIMEOUT. The flag is cleared only by reset.
- DSTALL_CNT increments on every DCACHE_STALL cycle.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Register x0 never causes a load-use stall.

Test Plan:
- Load x5 in EX (IDEX_MemRead=1, IDEX_RD=5), ID reads IFID_RS1=5 -> one cycle PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1; LU_STALL_CNT=1; next cycle all enables=1.
- Same as previous but IDEX_RD=0, or RS2 matching with IFID_USE_RS2=0 -> no stall, counter stays 0.
- FLUSH_EXTRA=2, EX_BranchTaken pulse -> cycle 0: PC_SRC=1 and both flushes; cycles 1-2: flushes=1, PC_SRC=0; cycle 3: RUN; FLUSH_CNT=1.
- DCACHE_STALL held 4 cycles while EX_BranchTaken=1 -> four cycles of all enables=0 with no PC_SRC; on release PC_SRC=1 once; DSTALL_CNT=4.
- TIMEOUT=3, DCACHE_STALL held 5 cycles -> STALL_TIMEOUT rises after the 3rd stalled cycle and stays 1 after the stall clears.
- Assert rst_n=0 mid-FLUSH, asynchronously between edges -> outputs take reset values immediately; after release state is RUN, counters=0.
